hilo_muldiv: RTL and testbench
==============================

Name: hilo_muldiv

Overview:
- Execute-stage HI/LO unit for the MIPS datapath.
- Consumes the main decoder's hilowrite control (10 = HI, 01 = LO, 11 = both) and a multiply/divide selector.
- Runs iterative MULT/MULTU/DIV/DIVU, performs MTHI/MTLO writes, and holds the architectural HI/LO registers.
- Stalls the pipeline while an iterative operation is in flight; MFHI/MFLO read hi_o/lo_o.

Parameters:
- WIDTH, 32, operand and HI/LO register width.
- CNT_W, 6, iteration counter width (must hold WIDTH).

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous, active-low reset.
- en  input  1  EX-stage instruction valid, not squashed.
- hilowrite  input  2  decoder control: 00 none, 10 write HI, 01 write LO, 11 mult/div.
- md_op  input  2  00 MULT, 01 MULTU, 10 DIV, 11 DIVU; used only when hilowrite=11.
- a  input  WIDTH  rs value (dividend / multiplicand / MTHI-MTLO source).
- b  input  WIDTH  rt value (divisor / multiplier).
- flush  input  1  exception/flush: abort any operation.
- hi_o  output  WIDTH  current HI register.
- lo_o  output  WIDTH  current LO register.
- stall  output  1  hold IF/ID/EX this cycle.
- busy  output  1  FSM not IDLE.

Behaviour:
- Reset (rst_n=0, async): HI=0, LO=0, FSM=IDLE, counter=0, stall=0, busy=0.
- FSM states: IDLE, CALC, DONE.
- IDLE:
  - en and hilowrite=10 -> HI<=a at the edge. No stall.
  - en and hilowrite=01 -> LO<=a at the edge. No stall.
  - en and hilowrite=11 -> start. stall=1 combinationally this cycle. Latch |a|, |b|, result-sign flags (signed ops only), md_op; counter<=0; go to CALC.
- CALC:
  - One radix-2 step per cycle: shift-add for multiply, restoring subtract for divide.
  - stall=1. After WIDTH steps (counter=WIDTH-1), go to DONE.
- DONE:
  - stall=0 so the pipeline advances. The held instruction still shows en/hilowrite=11 but must not restart.
  - {HI,LO}<=sign-corrected result at the end of the cycle; go to IDLE.
- Stall length: WIDTH+1 cycles (start + 32 CALC); result visible on hi_o/lo_o the cycle after DONE.
- Multiply: 64-bit product; HI=upper word, LO=lower word. Signed result negated (two's complement, 64-bit) if operand signs differ.
- Divide: LO=quotient, HI=remainder.
  - Signed: quotient negative iff signs differ; remainder takes the dividend's sign.
  - 0x80000000 / 0xFFFFFFFF -> LO=0x80000000, HI=0 (wraps, no trap).
- Divide by zero, any signedness: HI=a, LO=0xFFFFFFFF; normal latency.
- flush:
  - In any state: FSM<=IDLE, no HI/LO write.
  - In IDLE, suppresses MTHI/MTLO and start that cycle.
  - flush has priority over en.
- en=0 in IDLE: nothing changes.
- busy=1 in CALC and DONE.
- Operands are captured at start; later changes to a/b are ignored.
- Reset mid-operation: immediate IDLE, HI/LO=0.

Optional Feature:
- Macro HILO_FAST_MULT_EN.
- Defined: MULT/MULTU use a single-cycle combinational signed/unsigned 64-bit multiply. A start with a multiply goes IDLE->DONE directly: stall=1 for 1 cycle, DONE next cycle.
- Undefined: multiplies use the iterative path, same latency as divide.
- Divide path is identical either way.

Decomposition:
- Shared include defines.vh:
  - MD_MULT/MD_MULTU/MD_DIV/MD_DIVU codes.
  - HILO_W_HI(10)/HILO_W_LO(01)/HILO_W_BOTH(11).
  - State encodings IDLE/CALC/DONE.
- One sub-module, muldiv_iter: unsigned radix-2 shift-add/restoring-divide core with its own counter; ports start, mul_ndiv, x, y, done, res[2*WIDTH-1:0].
- hilo_muldiv owns the FSM, sign handling, HI/LO registers and stall.

Test Plan:
- Reset, then MTHI a=0x12345678, next cycle MTLO a=0x9ABCDEF0 -> hi_o=0x12345678, lo_o=0x9ABCDEF0, stall never high.
- MULT a=0xFFFFFFFD(-3), b=5 -> stall 33 cycles (1 with HILO_FAST_MULT_EN); then HI=0xFFFFFFFF, LO=0xFFFFFFF1.
- DIVU a=100, b=7 -> stall 33 cycles; then LO=14, HI=2. Same instruction held through DONE does not restart (busy=0 after).
- DIV a=0xFFFFFFF9(-7), b=2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF. DIV 0x80000000/0xFFFFFFFF -> LO=0x80000000, HI=0.
- DIVU a=0x55, b=0 -> HI=0x55, LO=0xFFFFFFFF after 33-cycle stall.
- Preload HI=LO=0x11111111. Start DIV, flush at CALC cycle 10 -> stall low next cycle, HI/LO unchanged. Repeat with rst_n low mid-CALC -> HI=LO=0, busy=0 immediately.

Source files
------------

// File: rtl/hilo_muldiv_pkg.sv
// Shared codes for the HI/LO multiply/divide unit: md_op encodings,
// hilowrite decoder controls, FSM state encoding and small op helpers.
package hilo_muldiv_pkg;

  localparam logic [1:0] MD_MULT  = 2'b00;
  localparam logic [1:0] MD_MULTU = 2'b01;
  localparam logic [1:0] MD_DIV   = 2'b10;
  localparam logic [1:0] MD_DIVU  = 2'b11;

  localparam logic [1:0] HILO_W_NONE = 2'b00;
  localparam logic [1:0] HILO_W_HI   = 2'b10;
  localparam logic [1:0] HILO_W_LO   = 2'b01;
  localparam logic [1:0] HILO_W_BOTH = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_CALC = 2'b01,
    ST_DONE = 2'b10
  } state_t;

  // MULT and DIV treat operands as two's complement; the U forms do not.
  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == MD_MULT) || (op == MD_DIV);
  endfunction

  // Multiplies have md_op[1] clear.
  function automatic logic is_mul_op(input logic [1:0] op);
    return ~op[1];
  endfunction

endpackage

// File: rtl/hilo_muldiv_iter.sv
// Unsigned radix-2 iterative core: shift-add multiply or restoring divide,
// one step per cycle, WIDTH steps after start. res holds {upper, lower}:
// product for multiply, {remainder, quotient} for divide. A new start
// always reloads, so an abandoned operation needs no explicit abort.
module hilo_muldiv_iter #(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               start,
  input  logic               mul_ndiv,
  input  logic [WIDTH-1:0]   x,
  input  logic [WIDTH-1:0]   y,
  output logic               done,
  output logic [2*WIDTH-1:0] res
);

  localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

  logic [2*WIDTH-1:0] acc_q;
  logic [2*WIDTH-1:0] acc_step;
  logic [WIDTH-1:0]   op_q;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_diff;
  logic [CNT_W-1:0]   cnt_q;
  logic               mul_q;
  logic               run_q;

  // done marks the cycle in which the final step is applied.
  assign done = run_q && (cnt_q == LAST);
  assign res  = acc_q;

  // One step: add-then-shift-right for multiply, shift-then-try-subtract for divide.
  always_comb begin
    mul_sum  = {1'b0, acc_q[2*WIDTH-1:WIDTH]} + {1'b0, (acc_q[0] ? op_q : '0)};
    div_diff = acc_q[2*WIDTH-1:WIDTH-1] - {1'b0, op_q};
    if (mul_q) begin
      acc_step = {mul_sum, acc_q[WIDTH-1:1]};
    end else if (!div_diff[WIDTH]) begin
      acc_step = {div_diff[WIDTH-1:0], acc_q[WIDTH-2:0], 1'b1};
    end else begin
      acc_step = {acc_q[2*WIDTH-2:0], 1'b0};
    end
  end

  // Operand load on start, then WIDTH iterations.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      acc_q <= '0;
      op_q  <= '0;
      cnt_q <= '0;
      mul_q <= 1'b0;
      run_q <= 1'b0;
    end else if (start) begin
      acc_q <= mul_ndiv ? {{WIDTH{1'b0}}, y} : {{WIDTH{1'b0}}, x};
      op_q  <= mul_ndiv ? x : y;
      mul_q <= mul_ndiv;
      cnt_q <= '0;
      run_q <= 1'b1;
    end else if (run_q) begin
      acc_q <= acc_step;
      cnt_q <= cnt_q + 1'b1;
      if (done) begin
        run_q <= 1'b0;
      end
    end
  end

endmodule

// File: rtl/hilo_muldiv.sv
// Execute-stage HI/LO unit: MTHI/MTLO writes, iterative MULT/MULTU/DIV/DIVU
// with sign handling around an unsigned core, and pipeline stall control.
// Optional macro HILO_FAST_MULT_EN: multiplies complete with a single-cycle
// combinational product (IDLE -> DONE), divides stay iterative.
//
// Handshake: there is no valid/ready pair; the unit holds IF/ID/EX with
// stall=1 from the start cycle through the last CALC cycle. In DONE stall
// drops so the held instruction retires, and it is never restarted there.
module hilo_muldiv
  import hilo_muldiv_pkg::*;
#(
  parameter int WIDTH = 32,
  parameter int CNT_W = 6
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       hilowrite,
  input  logic [1:0]       md_op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             flush,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o,
  output logic             stall,
  output logic             busy
);

  state_t state_q, state_d;

  logic [WIDTH-1:0]   hi_q, lo_q, a_q;
  logic [1:0]         op_q;
  logic               res_neg_q, rem_neg_q, div0_q;
  logic               start, wr_hi, wr_lo, wr_res;
  logic               fast_start, core_done;
  logic               op_signed, neg_a, neg_b;
  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH-1:0]   res_hi, res_lo;
  logic [2*WIDTH-1:0] core_res, mag_res;

  assign hi_o = hi_q;
  assign lo_o = lo_q;
  assign busy = (state_q != ST_IDLE);

  // Operand magnitudes for the unsigned core; signs only matter for MULT/DIV.
  always_comb begin
    op_signed = is_signed_op(md_op);
    neg_a     = op_signed & a[WIDTH-1];
    neg_b     = op_signed & b[WIDTH-1];
    abs_a     = neg_a ? -a : a;
    abs_b     = neg_b ? -b : b;
  end

`ifdef HILO_FAST_MULT_EN
  logic [2*WIDTH-1:0] fast_prod, prod_q;

  assign fast_start = is_mul_op(md_op);
  assign mag_res    = is_mul_op(op_q) ? prod_q : core_res;

  // Single-cycle magnitude product; sign is applied in DONE like the iterative path.
  always_comb begin
    fast_prod = {{WIDTH{1'b0}}, abs_a} * {{WIDTH{1'b0}}, abs_b};
  end

  // Hold the fast product until DONE writes it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prod_q <= '0;
    end else if (start && fast_start) begin
      prod_q <= fast_prod;
    end
  end
`else
  assign fast_start = 1'b0;
  assign mag_res    = core_res;
`endif

  hilo_muldiv_iter #(
    .WIDTH (WIDTH),
    .CNT_W (CNT_W)
  ) u_iter (
    .clk      (clk),
    .rst_n    (rst_n),
    .start    (start & ~fast_start),
    .mul_ndiv (is_mul_op(md_op)),
    .x        (abs_a),
    .y        (abs_b),
    .done     (core_done),
    .res      (core_res)
  );

  // Next state, stall and write strobes; flush beats en and aborts anything in flight.
  always_comb begin
    state_d = state_q;
    stall   = 1'b0;
    start   = 1'b0;
    wr_hi   = 1'b0;
    wr_lo   = 1'b0;
    wr_res  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (en && !flush) begin
          case (hilowrite)
            HILO_W_HI: wr_hi = 1'b1;
            HILO_W_LO: wr_lo = 1'b1;
            HILO_W_BOTH: begin
              start   = 1'b1;
              stall   = 1'b1;
              state_d = fast_start ? ST_DONE : ST_CALC;
            end
            default: ;
          endcase
        end
      end
      ST_CALC: begin
        stall = 1'b1;
        if (flush) begin
          state_d = ST_IDLE;
        end else if (core_done) begin
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        wr_res  = !flush;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Sign-corrected result; divide by zero returns HI=dividend, LO=all ones.
  always_comb begin
    res_hi = '0;
    res_lo = '0;
    if (is_mul_op(op_q)) begin
      {res_hi, res_lo} = res_neg_q ? -mag_res : mag_res;
    end else if (div0_q) begin
      res_hi = a_q;
      res_lo = '1;
    end else begin
      res_lo = res_neg_q ? -mag_res[WIDTH-1:0] : mag_res[WIDTH-1:0];
      res_hi = rem_neg_q ? -mag_res[2*WIDTH-1:WIDTH] : mag_res[2*WIDTH-1:WIDTH];
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Operation context captured at start so later a/b changes are ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_q      <= MD_MULT;
      a_q       <= '0;
      div0_q    <= 1'b0;
      res_neg_q <= 1'b0;
      rem_neg_q <= 1'b0;
    end else if (start) begin
      op_q      <= md_op;
      a_q       <= a;
      div0_q    <= (b == '0);
      res_neg_q <= neg_a ^ neg_b;
      rem_neg_q <= neg_a;
    end
  end

  // Architectural HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hi_q <= '0;
      lo_q <= '0;
    end else if (wr_res) begin
      hi_q <= res_hi;
      lo_q <= res_lo;
    end else begin
      if (wr_hi) hi_q <= a;
      if (wr_lo) lo_q <= a;
    end
  end

endmodule

// File: tb/tb_hilo_muldiv.sv
// Directed bench for hilo_muldiv: MTHI/MTLO, signed/unsigned multiply and
// divide, divide by zero, flush in IDLE and mid-CALC, reset mid-CALC.
module tb_hilo_muldiv;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        en;
  logic        flush;
  logic [1:0]  hilowrite;
  logic [1:0]  md_op;
  logic [31:0] a, b;
  logic [31:0] hi_o, lo_o;
  logic        stall, busy;

  int errors = 0;
  int checks = 0;

`ifdef HILO_FAST_MULT_EN
  localparam int MUL_STALL = 1;
`else
  localparam int MUL_STALL = 33;
`endif
  localparam int DIV_STALL = 33;

  hilo_muldiv #(.WIDTH(32), .CNT_W(6)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .en        (en),
    .hilowrite (hilowrite),
    .md_op     (md_op),
    .a         (a),
    .b         (b),
    .flush     (flush),
    .hi_o      (hi_o),
    .lo_o      (lo_o),
    .stall     (stall),
    .busy      (busy)
  );

  // Clock and watchdog.
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, got, exp);
    end
  endtask

  // Advance one clock; outputs are then sampled 1 time unit after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Issue a mult/div, count stall cycles, hold the instruction through DONE,
  // then release it and check HI/LO and that no restart happened.
  task automatic run_op(input string tag, input logic [1:0] op,
                        input logic [31:0] av, input logic [31:0] bv,
                        input int exp_stall,
                        input logic [31:0] exp_hi, input logic [31:0] exp_lo);
    int n;
    en = 1'b1; hilowrite = 2'b11; md_op = op; a = av; b = bv;
    #1;
    n = 0;
    while (stall === 1'b1 && n < 100) begin
      n++;
      tick();
      a = ~av;
      b = ~bv;
      #1;
    end
    chk({tag, "_stall_cycles"}, n, exp_stall);
    chk({tag, "_busy_done"}, {31'b0, busy}, 32'd1);
    tick();
    en = 1'b0; hilowrite = 2'b00;
    #1;
    chk({tag, "_busy_after"}, {31'b0, busy}, 32'd0);
    chk({tag, "_hi"}, hi_o, exp_hi);
    chk({tag, "_lo"}, lo_o, exp_lo);
  endtask

  initial begin
    rst_n = 1'b0; en = 1'b0; flush = 1'b0; hilowrite = 2'b00;
    md_op = 2'b00; a = '0; b = '0;
    tick();
    tick();
    chk("reset_hi", hi_o, 32'h0);
    chk("reset_lo", lo_o, 32'h0);
    chk("reset_stall", {31'b0, stall}, 32'd0);
    chk("reset_busy", {31'b0, busy}, 32'd0);
    rst_n = 1'b1;
    tick();

    // MTHI then MTLO
    en = 1'b1; hilowrite = 2'b10; a = 32'h12345678;
    #1;
    chk("mthi_stall", {31'b0, stall}, 32'd0);
    tick();
    hilowrite = 2'b01; a = 32'h9ABCDEF0;
    #1;
    chk("mtlo_stall", {31'b0, stall}, 32'd0);
    chk("mthi_hi", hi_o, 32'h12345678);
    tick();
    en = 1'b0; hilowrite = 2'b00;
    #1;
    chk("mtlo_lo", lo_o, 32'h9ABCDEF0);
    chk("mtlo_hi_kept", hi_o, 32'h12345678);

    // en=0 in IDLE changes nothing
    hilowrite = 2'b10; a = 32'hDEADBEEF;
    tick();
    chk("en0_hi", hi_o, 32'h12345678);

    // flush in IDLE suppresses MTLO and start
    en = 1'b1; flush = 1'b1; hilowrite = 2'b01;
    tick();
    chk("flush_mtlo_lo", lo_o, 32'h9ABCDEF0);
    hilowrite = 2'b11; md_op = 2'b11;
    #1;
    chk("flush_start_stall", {31'b0, stall}, 32'd0);
    tick();
    chk("flush_start_busy", {31'b0, busy}, 32'd0);
    flush = 1'b0; en = 1'b0; hilowrite = 2'b00;
    tick();

    // Multiplies and divides
    run_op("mult_neg3x5", 2'b00, 32'hFFFFFFFD, 32'd5, MUL_STALL, 32'hFFFFFFFF, 32'hFFFFFFF1);
    run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, MUL_STALL, 32'hFFFFFFFE, 32'h00000001);
    run_op("divu_100_7", 2'b11, 32'd100, 32'd7, DIV_STALL, 32'd2, 32'd14);
    run_op("div_neg7_2", 2'b10, 32'hFFFFFFF9, 32'd2, DIV_STALL, 32'hFFFFFFFF, 32'hFFFFFFFD);
    run_op("div_7_neg2", 2'b10, 32'd7, 32'hFFFFFFFE, DIV_STALL, 32'd1, 32'hFFFFFFFD);
    run_op("div_min_neg1", 2'b10, 32'h80000000, 32'hFFFFFFFF, DIV_STALL, 32'h0, 32'h80000000);
    run_op("divu_by0", 2'b11, 32'h55, 32'h0, DIV_STALL, 32'h55, 32'hFFFFFFFF);
    run_op("div_neg_by0", 2'b10, 32'hFFFFFF00, 32'h0, DIV_STALL, 32'hFFFFFF00, 32'hFFFFFFFF);
    tick();
    chk("no_restart_busy", {31'b0, busy}, 32'd0);

    // Preload HI=LO=0x11111111, then flush a DIV at CALC cycle 10
    en = 1'b1; hilowrite = 2'b10; a = 32'h11111111;
    tick();
    hilowrite = 2'b01;
    tick();
    hilowrite = 2'b11; md_op = 2'b10; a = 32'd100; b = 32'd7;
    tick();
    repeat (10) tick();
    chk("flush_calc_busy", {31'b0, busy}, 32'd1);
    en = 1'b0; hilowrite = 2'b00; flush = 1'b1;
    tick();
    flush = 1'b0;
    #1;
    chk("flush_calc_stall", {31'b0, stall}, 32'd0);
    chk("flush_calc_busy_after", {31'b0, busy}, 32'd0);
    chk("flush_calc_hi", hi_o, 32'h11111111);
    chk("flush_calc_lo", lo_o, 32'h11111111);
    repeat (40) tick();
    chk("flush_late_hi", hi_o, 32'h11111111);
    chk("flush_late_lo", lo_o, 32'h11111111);

    // Reset asserted mid-CALC
    en = 1'b1; hilowrite = 2'b11; md_op = 2'b11; a = 32'd1000; b = 32'd3;
    tick();
    repeat (5) tick();
    en = 1'b0; hilowrite = 2'b00;
    #2;
    rst_n = 1'b0;
    #1;
    chk("rst_mid_hi", hi_o, 32'h0);
    chk("rst_mid_lo", lo_o, 32'h0);
    chk("rst_mid_busy", {31'b0, busy}, 32'd0);
    chk("rst_mid_stall", {31'b0, stall}, 32'd0);
    tick();
    rst_n = 1'b1;
    repeat (40) tick();
    chk("rst_after_busy", {31'b0, busy}, 32'd0);
    chk("rst_after_lo", lo_o, 32'h0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
